load_store_unit: RTL
====================

// Module: load_store_unit
// PURPOSE
//   Load/store unit between EX and the data SRAM of the RV32I core. It takes the ALU
//   address, the rs2 store data and funct3, and drives an external synchronous SRAM
//   with byte enables. Read latency is a fixed parameter, and the unit stalls the PC
//   while a load is outstanding. Loaded data is formatted (LB/LH/LW/LBU/LHU) before WB.
// PARAMETERS
//   AW        10  word-address width of the SRAM; mem_addr = addr[AW+1:2]
//   READ_LAT  1   SRAM read latency in cycles, legal range 1..4
// PORTS
//   clk          in   1   core clock, all state updates on rising edge
//   rst          in   1   synchronous reset, active-high
//   req_valid    in   1   memory instruction present this cycle (load or store)
//   req_we       in   1   1 = store, 0 = load
//   funct3       in   3   RV32I width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   addr         in   32  byte address from ALU
//   wdata        in   32  store data (rs2)
//   stall        out  1   hold PC/pipeline; the request must stay stable while high
//   rdata        out  32  formatted load result to WB
//   rdata_valid  out  1   rdata is valid this cycle (one-cycle pulse)
//   access_err   out  1   misaligned or illegal funct3; no memory access made
//   mem_en       out  1   SRAM access strobe
//   mem_we       out  1   SRAM write strobe
//   mem_be       out  4   SRAM byte enables
//   mem_addr     out  AW  SRAM word address
//   mem_wdata    out  32  SRAM write data, byte-lane replicated
//   mem_rdata    in   32  SRAM read data, valid READ_LAT cycles after the mem_en read
// BEHAVIOUR
//   FSM states: IDLE, WAIT, DONE. Reset (or any cycle with rst=1): state=IDLE, count=0,
//     and all outputs are 0.
//   Error check (combinational): W requires addr[1:0]==0. H/HU requires addr[0]==0.
//     funct3 of 011, 110 or 111 is illegal for loads; for stores only 000/001/010 are legal.
//     On error: access_err=1 for that cycle, mem_en=0, stall=0, rdata=0, rdata_valid=0.
//   Store in IDLE (no error): in the same cycle mem_en=1, mem_we=1, stall=0, and the FSM
//     stays in IDLE. SB: be=1<<addr[1:0], wdata={4{wdata[7:0]}}.
//     SH: be=addr[1]?4'b1100:4'b0011, wdata={2{wdata[15:0]}}. SW: be=4'b1111.
//   Load in IDLE (no error): mem_en=1, mem_we=0, be=4'b1111, stall=1. Latch addr[1:0]
//     and funct3. Go to WAIT with count=READ_LAT-1. If READ_LAT==1, go directly to DONE.
//   WAIT: stall=1, mem_en=0. Decrement count; when count reaches 1, the next state is DONE.
//   DONE: the cycle that is READ_LAT cycles after the issue cycle. stall=0, rdata_valid=1,
//     rdata=format(mem_rdata) using the latched offset and funct3. The held request is
//     consumed and not re-issued. Next state is IDLE.
//   Format rules: B/BU select the byte at the offset; H/HU select the half at offset[1].
//     B/H sign-extend from bit 7/15; BU/HU zero-fill.
//   Total stall per load = READ_LAT cycles. Stores and errors cost 0 stall cycles.
//   req_valid=0 in IDLE: all mem_* outputs are 0 and the FSM stays in IDLE.
//   req inputs are ignored in WAIT/DONE; the core guarantees they are held.
//   rst during WAIT/DONE: return to IDLE on that edge. The pending load is discarded,
//     rdata_valid is never raised for it, and stall drops in the next cycle.
//   mem_addr always equals addr[AW+1:2] of the accepted request. Upper address bits are
//     ignored (wrap-around at 4*2^AW bytes).
// TESTING
//   1 SW addr=0x10 wdata=0xDEADBEEF -> same cycle: mem_we=1, be=1111, mem_addr=4,
//     mem_wdata=0xDEADBEEF, stall=0
//   2 SB addr=0x13 wdata=0x000000A5 -> be=1000, mem_wdata=0xA5A5A5A5; then LW 0x10 returns
//     0xA5ADBEEF
//   3 READ_LAT=1, LB addr=0x13, mem_rdata=0x80FF1234 -> stall=1 for 1 cycle, then
//     rdata=0xFFFFFF80 with rdata_valid=1
//   4 READ_LAT=3, LHU addr=0x12, mem_rdata=0x80FF1234 -> stall=1 for 3 cycles, then
//     rdata=0x000080FF; LH at the same address returns 0xFFFF80FF
//   5 LW addr=0x06 and SH addr=0x11 -> access_err=1, mem_en=0, stall=0; funct3=011 load
//     also gives access_err=1
//   6 READ_LAT=3, issue LW, assert rst in the 2nd WAIT cycle -> next cycle: stall=0,
//     all outputs 0, and no rdata_valid pulse follows

Source files
------------

// File: rtl/load_store_unit.sv
// RV32I load/store unit: drives a synchronous SRAM with byte enables and stalls the pipeline
// for a fixed read latency, then formats the returned word for writeback.
module load_store_unit #(
    parameter int unsigned AW       = 10,
    parameter int unsigned READ_LAT = 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          req_valid_i,
    input  logic          req_we_i,
    input  logic [2:0]    funct3_i,
    input  logic [31:0]   addr_i,
    input  logic [31:0]   wdata_i,
    output logic          stall_o,
    output logic [31:0]   rdata_o,
    output logic          rdata_valid_o,
    output logic          access_err_o,
    output logic          mem_en_o,
    output logic          mem_we_o,
    output logic [3:0]    mem_be_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [31:0]   mem_wdata_o,
    input  logic [31:0]   mem_rdata_i
);

    typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

    state_e        state_q, state_d;
    logic [2:0]    count_q, count_d;
    logic [1:0]    off_q, off_d;
    logic [2:0]    f3_q, f3_d;
    logic [AW-1:0] addr_q, addr_d;

    logic        err;
    logic        f3_legal;
    logic        misaligned;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_fmt;

    // Upper address bits wrap around the SRAM and are deliberately dropped.
    logic unused_addr;
    assign unused_addr = ^addr_i[31:AW+2];

    always_comb begin
        f3_legal   = 1'b0;
        misaligned = 1'b0;
        unique case (funct3_i)
            3'b000:         f3_legal = 1'b1;
            3'b001:         f3_legal = 1'b1;
            3'b010:         f3_legal = 1'b1;
            3'b100, 3'b101: f3_legal = ~req_we_i;
            default:        f3_legal = 1'b0;
        endcase
        if (funct3_i == 3'b010) begin
            misaligned = addr_i[1:0] != 2'b00;
        end else if (funct3_i[1:0] == 2'b01) begin
            misaligned = addr_i[0];
        end
        err = ~f3_legal | misaligned;
    end

    always_comb begin
        unique case (off_q)
            2'd0:    ld_byte = mem_rdata_i[7:0];
            2'd1:    ld_byte = mem_rdata_i[15:8];
            2'd2:    ld_byte = mem_rdata_i[23:16];
            default: ld_byte = mem_rdata_i[31:24];
        endcase
        ld_half = off_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        unique case (f3_q)
            3'b000:  ld_fmt = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_fmt = {24'b0, ld_byte};
            3'b001:  ld_fmt = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_fmt = {16'b0, ld_half};
            default: ld_fmt = mem_rdata_i;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        off_d         = off_q;
        f3_d          = f3_q;
        addr_d        = addr_q;
        stall_o       = 1'b0;
        rdata_o       = 32'b0;
        rdata_valid_o = 1'b0;
        access_err_o  = 1'b0;
        mem_en_o      = 1'b0;
        mem_we_o      = 1'b0;
        mem_be_o      = 4'b0;
        mem_addr_o    = '0;
        mem_wdata_o   = 32'b0;

        // While reset is high every output stays low, even mid-load.
        if (!rst_i) begin
            unique case (state_q)
                StIdle: begin
                    if (req_valid_i) begin
                        if (err) begin
                            access_err_o = 1'b1;
                        end else if (req_we_i) begin
                            mem_en_o   = 1'b1;
                            mem_we_o   = 1'b1;
                            mem_addr_o = addr_i[AW+1:2];
                            unique case (funct3_i[1:0])
                                2'b00: begin
                                    mem_be_o    = 4'b0001 << addr_i[1:0];
                                    mem_wdata_o = {4{wdata_i[7:0]}};
                                end
                                2'b01: begin
                                    mem_be_o    = addr_i[1] ? 4'b1100 : 4'b0011;
                                    mem_wdata_o = {2{wdata_i[15:0]}};
                                end
                                default: begin
                                    mem_be_o    = 4'b1111;
                                    mem_wdata_o = wdata_i;
                                end
                            endcase
                        end else begin
                            mem_en_o   = 1'b1;
                            mem_be_o   = 4'b1111;
                            mem_addr_o = addr_i[AW+1:2];
                            stall_o    = 1'b1;
                            off_d      = addr_i[1:0];
                            f3_d       = funct3_i;
                            addr_d     = addr_i[AW+1:2];
                            count_d    = 3'(READ_LAT - 1);
                            state_d    = (READ_LAT == 1) ? StDone : StWait;
                        end
                    end
                end
                StWait: begin
                    stall_o    = 1'b1;
                    mem_addr_o = addr_q;
                    count_d    = count_q - 3'd1;
                    if (count_q <= 3'd1) begin
                        state_d = StDone;
                    end
                end
                StDone: begin
                    mem_addr_o    = addr_q;
                    rdata_valid_o = 1'b1;
                    rdata_o       = ld_fmt;
                    count_d       = 3'd0;
                    state_d       = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            count_q <= 3'd0;
            off_q   <= 2'd0;
            f3_q    <= 3'd0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            off_q   <= off_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
        end
    end

endmodule
